// File: rtl/seq_mag_comparator_if.sv
// rtl/seq_mag_comparator_if.sv - start/done handshake and result bundle for seq_mag_comparator
interface seq_mag_comparator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_eq_b;
    logic             a_ls_b;
    logic             a_gr_b;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, a_eq_b, a_ls_b, a_gr_b
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, a_eq_b, a_ls_b, a_gr_b
    );
endinterface

// File: rtl/seq_mag_comparator.sv
// rtl/seq_mag_comparator.sv - multi-cycle chunked magnitude comparator, MSB chunk first, early exit
module seq_mag_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_mag_comparator_if.slave  cmp
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d;
    logic             ls_q, ls_d;
    logic             gr_q, gr_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;

    // Operands shift left as chunks match, so the chunk under test is always on top.
    assign chunk_a = ra_q[WIDTH-1 -: CHUNK];
    assign chunk_b = rb_q[WIDTH-1 -: CHUNK];

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        eq_d    = eq_q;
        ls_d    = ls_q;
        gr_d    = gr_q;
        case (state_q)
            IDLE: begin
                if (cmp.start) begin
                    // Flipping the sign bit maps two's complement onto offset binary.
                    ra_d    = cmp.a ^ (cmp.signed_mode ? MSB_MASK : '0);
                    rb_d    = cmp.b ^ (cmp.signed_mode ? MSB_MASK : '0);
                    idx_d   = '0;
                    eq_d    = 1'b0;
                    ls_d    = 1'b0;
                    gr_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (chunk_a != chunk_b) begin
                    gr_d    = chunk_a > chunk_b;
                    ls_d    = chunk_a < chunk_b;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (idx_q == LAST_IDX) begin
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                    ra_d  = ra_q << CHUNK;
                    rb_d  = rb_q << CHUNK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            ls_q    <= 1'b0;
            gr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            ls_q    <= ls_d;
            gr_q    <= gr_d;
        end
    end

    assign cmp.busy   = busy_q;
    assign cmp.done   = done_q;
    assign cmp.a_eq_b = eq_q;
    assign cmp.a_ls_b = ls_q;
    assign cmp.a_gr_b = gr_q;
endmodule

// File: tb/tb_seq_mag_comparator.sv
// tb/tb_seq_mag_comparator.sv - table-driven scoreboard bench for seq_mag_comparator
module tb_seq_mag_comparator;
    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    localparam logic [2:0] F_EQ = 3'b100;
    localparam logic [2:0] F_LS = 3'b010;
    localparam logic [2:0] F_GR = 3'b001;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_mag_comparator_if #(.WIDTH(WIDTH)) cmp_if ();

    seq_mag_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmp   (cmp_if.slave)
    );

    typedef struct {
        logic        sm;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  flags;
        int          lat;
    } vec_t;

    typedef struct {
        logic [2:0] flags;
        int         lat;
        int         start_cyc;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[10];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] flags_now();
        return {cmp_if.a_eq_b, cmp_if.a_ls_b, cmp_if.a_gr_b};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmp_if.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, " flags"}, 32'(flags_now()), 32'(mon_e.flags));
                    check({mon_e.name, " latency"}, 32'(cyc - mon_e.start_cyc), 32'(mon_e.lat));
                    check({mon_e.name, " busy_at_done"}, 32'(cmp_if.busy), 32'd0);
                end
            end else if (sb.size() > 0 && cyc >= sb[0].start_cyc) begin
                check({sb[0].name, " busy_running"}, 32'(cmp_if.busy), 32'd1);
                check({sb[0].name, " flags_running"}, 32'(flags_now()), 32'd0);
            end
        end
    end

    task automatic issue(input logic sm, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] flags, input int lat, input string name);
        exp_t e;
        cmp_if.start       = 1'b1;
        cmp_if.signed_mode = sm;
        cmp_if.a           = a;
        cmp_if.b           = b;
        e.flags     = flags;
        e.lat       = lat;
        e.start_cyc = cyc + 1;
        e.name      = name;
        sb.push_back(e);
    endtask

    task automatic release_start();
        cmp_if.start       = 1'b0;
        cmp_if.signed_mode = 1'($urandom);
        cmp_if.a           = 16'($urandom);
        cmp_if.b           = 16'($urandom);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (i == 40) begin
            check("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    function automatic logic [2:0] model_flags(input logic sm, input logic [15:0] a, input logic [15:0] b);
        if (a == b) return F_EQ;
        if (sm) return ($signed(a) < $signed(b)) ? F_LS : F_GR;
        return (a < b) ? F_LS : F_GR;
    endfunction

    function automatic int model_lat(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        x = a ^ b;
        for (int k = 0; k < NCHUNK; k++) begin
            if (x[WIDTH-1-k*CHUNK -: CHUNK] != '0) return k + 1;
        end
        return NCHUNK;
    endfunction

    initial begin
        tbl[0] = '{1'b0, 16'h8000, 16'h7FFF, F_GR, 1};
        tbl[1] = '{1'b0, 16'h1233, 16'h1234, F_LS, 4};
        tbl[2] = '{1'b1, 16'hA5A5, 16'hA5A5, F_EQ, 4};
        tbl[3] = '{1'b0, 16'hA5A5, 16'hA5A5, F_EQ, 4};
        tbl[4] = '{1'b1, 16'hFFFF, 16'h0001, F_LS, 1};
        tbl[5] = '{1'b0, 16'hFFFF, 16'h0001, F_GR, 1};
        tbl[6] = '{1'b1, 16'h8000, 16'h7FFF, F_LS, 1};
        tbl[7] = '{1'b1, 16'h0010, 16'h0020, F_LS, 3};
        tbl[8] = '{1'b0, 16'h0300, 16'h0200, F_GR, 2};
        tbl[9] = '{1'b1, 16'hFFFE, 16'hFFFF, F_LS, 4};

        cmp_if.start       = 1'b0;
        cmp_if.signed_mode = 1'b0;
        cmp_if.a           = '0;
        cmp_if.b           = '0;

        repeat (2) @(negedge clk);
        check("reset busy", 32'(cmp_if.busy), 32'd0);
        check("reset done", 32'(cmp_if.done), 32'd0);
        check("reset flags", 32'(flags_now()), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            issue(tbl[i].sm, tbl[i].a, tbl[i].b, tbl[i].flags, tbl[i].lat, $sformatf("vec%0d", i));
            @(negedge clk);
            release_start();
            wait_idle();
        end

        // Flags must persist after done until the next accepted start.
        @(negedge clk);
        issue(1'b0, 16'h1233, 16'h1234, F_LS, 4, "hold");
        @(negedge clk);
        release_start();
        wait_idle();
        repeat (3) @(negedge clk);
        check("hold flags", 32'(flags_now()), 32'(F_LS));

        // A second start while running must be ignored.
        @(negedge clk);
        issue(1'b0, 16'h1233, 16'h1234, F_LS, 4, "ignore");
        @(negedge clk);
        release_start();
        @(negedge clk);
        cmp_if.start = 1'b1;
        cmp_if.a     = 16'hFFFF;
        cmp_if.b     = 16'h0000;
        @(negedge clk);
        release_start();
        wait_idle();
        repeat (6) @(negedge clk);
        check("ignore no_second_run", 32'(cmp_if.busy), 32'd0);

        // Start accepted in the same cycle that done is high.
        @(negedge clk);
        issue(1'b0, 16'h8000, 16'h7FFF, F_GR, 1, "b2b_first");
        @(negedge clk);
        release_start();
        begin
            int j;
            for (j = 0; j < 10; j++) begin
                if (cmp_if.done) break;
                @(negedge clk);
            end
            check("b2b done_seen", 32'(j < 10), 32'd1);
        end
        issue(1'b0, 16'h0000, 16'h0001, F_LS, 4, "b2b_second");
        @(negedge clk);
        release_start();
        check("b2b flags_cleared", 32'(flags_now()), 32'd0);
        wait_idle();

        // Randomised operands that share upper chunks to exercise each exit point.
        for (int i = 0; i < 8; i++) begin
            logic        sm;
            logic [15:0] a, b;
            int          k;
            sm = 1'($urandom);
            a  = 16'($urandom);
            k  = $urandom_range(0, NCHUNK - 1);
            b  = a ^ (16'($urandom_range(0, 15)) << (WIDTH - (k + 1) * CHUNK));
            @(negedge clk);
            issue(sm, a, b, model_flags(sm, a, b), model_lat(a, b), $sformatf("rnd%0d", i));
            @(negedge clk);
            release_start();
            wait_idle();
        end

        // Reset two cycles into an equal-operand compare aborts it silently.
        @(negedge clk);
        cmp_if.start       = 1'b1;
        cmp_if.signed_mode = 1'b0;
        cmp_if.a           = 16'h5A5A;
        cmp_if.b           = 16'h5A5A;
        @(negedge clk);
        release_start();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(cmp_if.busy), 32'd0);
        check("abort done", 32'(cmp_if.done), 32'd0);
        check("abort flags", 32'(flags_now()), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int done_cnt;
            done_cnt = 0;
            repeat (8) begin
                @(negedge clk);
                if (cmp_if.done) done_cnt++;
            end
            check("abort no_done", 32'(done_cnt), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
